// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Default 640x480@60 VGA timing constants shared by the sync generator.
// Line/frame order is: sync, back porch, active, front porch, with count 0
// being the first sync clock/line. The derived active-window bounds are
// half-open: START <= pos < END.
// ---------------------------------------------------------------------------
package vga_timing_pkg;

  // Horizontal timing, in pixel clocks
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;

  // Vertical timing, in lines
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;

  // Derived totals and visible-window bounds
  localparam int DEF_H_TOTAL     = DEF_H_SYNC + DEF_H_BP + DEF_H_ACTIVE + DEF_H_FP;
  localparam int DEF_V_TOTAL     = DEF_V_SYNC + DEF_V_BP + DEF_V_ACTIVE + DEF_V_FP;
  localparam int DEF_H_ACT_START = DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_H_ACT_END   = DEF_H_ACT_START + DEF_H_ACTIVE;
  localparam int DEF_V_ACT_START = DEF_V_SYNC + DEF_V_BP;
  localparam int DEF_V_ACT_END   = DEF_V_ACT_START + DEF_V_ACTIVE;

  // Counter width: must hold DEF_H_TOTAL-1 and DEF_V_TOTAL-1
  localparam int DEF_CW = 10;

endpackage : vga_timing_pkg

// File: rtl/vga_sync_gen_wrap_counter.sv
// ---------------------------------------------------------------------------
// wrap_counter
// Enable-gated up counter that returns to 0 after reaching MAX.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, count -> 0
//   en    : advance the count this cycle
//   count : current count, 0..MAX
//   wrap  : en && (count == MAX), i.e. the count returns to 0 on this edge
// ---------------------------------------------------------------------------
module wrap_counter #(
  parameter int WIDTH = 10,
  parameter int MAX   = 799
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next-count selection: hold, increment, or wrap to zero at MAX
  always_comb begin
    count_d = count_q;
    if (en) begin
      if (count_q == MAX_C) begin
        count_d = '0;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign wrap  = en && (count_q == MAX_C);

endmodule : wrap_counter

// File: rtl/vga_sync_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_gen
// VGA timing generator: a horizontal pixel counter and a vertical line
// counter, with sync/blank outputs decoded combinationally from the
// registered counters (no extra latency relative to posx/posy).
//   clk     : pixel clock, rising edge
//   rst     : synchronous active-high reset, (posx,posy) -> (0,0)
//   h_sync  : horizontal sync, active low while posx < H_SYNC
//   v_sync  : vertical sync, active low while posy < V_SYNC
//   blank_n : 1 inside the visible window, 0 during blanking
//   sync_n  : composite sync to the DAC, h_sync ^ v_sync
//   posx    : horizontal count, 0..H_TOTAL-1
//   posy    : vertical count, 0..V_TOTAL-1
// ---------------------------------------------------------------------------
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int CW       = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  output logic          h_sync,
  output logic          v_sync,
  output logic          blank_n,
  output logic          sync_n,
  output logic [CW-1:0] posx,
  output logic [CW-1:0] posy
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  // Decode thresholds as CW-bit unsigned values so every compare is CW-bit
  localparam logic [CW-1:0] H_SYNC_C      = CW'(H_SYNC);
  localparam logic [CW-1:0] V_SYNC_C      = CW'(V_SYNC);
  localparam logic [CW-1:0] H_ACT_START_C = CW'(H_SYNC + H_BP);
  localparam logic [CW-1:0] H_ACT_END_C   = CW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_START_C = CW'(V_SYNC + V_BP);
  localparam logic [CW-1:0] V_ACT_END_C   = CW'(V_SYNC + V_BP + V_ACTIVE);

  logic h_wrap_s;
  logic v_wrap_unused_s;  // end-of-frame pulse, not needed at this level
  logic h_sync_s;
  logic v_sync_s;
  logic h_vis_s;
  logic v_vis_s;

  // Pixel counter runs every clock
  wrap_counter #(
    .WIDTH (CW),
    .MAX   (H_TOTAL - 1)
  ) u_h_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .count (posx),
    .wrap  (h_wrap_s)
  );

  // Line counter advances only on the last pixel of each line, so both
  // counters wrap together at the end of the frame
  wrap_counter #(
    .WIDTH (CW),
    .MAX   (V_TOTAL - 1)
  ) u_v_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (h_wrap_s),
    .count (posy),
    .wrap  (v_wrap_unused_s)
  );

  // Sync and blanking decode from the current counter values
  always_comb begin
    h_sync_s = (posx < H_SYNC_C) ? 1'b0 : 1'b1;
    v_sync_s = (posy < V_SYNC_C) ? 1'b0 : 1'b1;
    h_vis_s  = (posx >= H_ACT_START_C) && (posx < H_ACT_END_C);
    v_vis_s  = (posy >= V_ACT_START_C) && (posy < V_ACT_END_C);
  end

  assign h_sync  = h_sync_s;
  assign v_sync  = v_sync_s;
  assign blank_n = h_vis_s & v_vis_s;
  assign sync_n  = h_sync_s ^ v_sync_s;

endmodule : vga_sync_gen

// File: tb/tb_vga_sync_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_gen
// Drives a default 640x480 instance and a small override instance
// (H 2/2/8/2, V 1/1/4/1 -> 14 x 7) from a shared clock and reset. Every
// clock, an integer beam model pushes the expected outputs of both
// instances into scoreboards that are popped and compared on the falling
// edge. Scenario tasks add directed checks on top.
// ---------------------------------------------------------------------------
module tb_vga_sync_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hs_b, vs_b, bn_b, sn_b;
  logic [9:0] px_b, py_b;
  logic       hs_s, vs_s, bn_s, sn_s;
  logic [9:0] px_s, py_s;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       bn;
    logic       sn;
  } obs_t;

  obs_t q_b[$];
  obs_t q_s[$];
  int   mx_b = 0, my_b = 0, mx_s = 0, my_s = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   vs_low_b = 0;  // v_sync-low observations on the big DUT outside reset

  always #5 clk = ~clk;

  vga_sync_gen dut (
    .clk(clk), .rst(rst), .h_sync(hs_b), .v_sync(vs_b),
    .blank_n(bn_b), .sync_n(sn_b), .posx(px_b), .posy(py_b)
  );

  vga_sync_gen #(
    .H_SYNC(2), .H_BP(2), .H_ACTIVE(8), .H_FP(2),
    .V_SYNC(1), .V_BP(1), .V_ACTIVE(4), .V_FP(1)
  ) dut_s (
    .clk(clk), .rst(rst), .h_sync(hs_s), .v_sync(vs_s),
    .blank_n(bn_s), .sync_n(sn_s), .posx(px_s), .posy(py_s)
  );

  // Expected outputs for beam position (x,y) under the given timing
  function automatic obs_t expect_of(int x, int y, int hsy, int hbp, int hact,
                                     int vsy, int vbp, int vact);
    obs_t e;
    e.x  = x[9:0];
    e.y  = y[9:0];
    e.hs = (x < hsy) ? 1'b0 : 1'b1;
    e.vs = (y < vsy) ? 1'b0 : 1'b1;
    e.bn = (x >= hsy + hbp) && (x < hsy + hbp + hact) &&
           (y >= vsy + vbp) && (y < vsy + vbp + vact);
    e.sn = (e.hs != e.vs);
    return e;
  endfunction

  // Beam position after one clock edge
  function automatic void adv(inout int x, inout int y, input int xmax,
                              input int ymax, input logic r);
    if (r) begin
      x = 0;
      y = 0;
    end else if (x == xmax) begin
      x = 0;
      y = (y == ymax) ? 0 : y + 1;
    end else begin
      x = x + 1;
    end
  endfunction

  // One clock: model + push on the rising edge, pop + compare on the falling edge
  task automatic tick();
    obs_t e;
    obs_t a;
    @(posedge clk);
    adv(mx_b, my_b, 799, 524, rst);
    adv(mx_s, my_s, 13, 6, rst);
    q_b.push_back(expect_of(mx_b, my_b, 96, 48, 640, 2, 33, 480));
    q_s.push_back(expect_of(mx_s, my_s, 2, 2, 8, 1, 1, 4));
    @(negedge clk);
    a = {px_b, py_b, hs_b, vs_b, bn_b, sn_b};
    e = q_b.pop_front();
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL sb_big: got x=%0d y=%0d hs=%b vs=%b bn=%b sn=%b, expected x=%0d y=%0d hs=%b vs=%b bn=%b sn=%b",
               a.x, a.y, a.hs, a.vs, a.bn, a.sn, e.x, e.y, e.hs, e.vs, e.bn, e.sn);
    end
    a = {px_s, py_s, hs_s, vs_s, bn_s, sn_s};
    e = q_s.pop_front();
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL sb_small: got x=%0d y=%0d hs=%b vs=%b bn=%b sn=%b, expected x=%0d y=%0d hs=%b vs=%b bn=%b sn=%b",
               a.x, a.y, a.hs, a.vs, a.bn, a.sn, e.x, e.y, e.hs, e.vs, e.bn, e.sn);
    end
    if (!rst && !vs_b) vs_low_b++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_tests++;
    if ({px_b, py_b, hs_b, vs_b, bn_b, sn_b} !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_big: got x=%0d y=%0d outs=%b, expected all zero",
               px_b, py_b, {hs_b, vs_b, bn_b, sn_b});
    end
    n_tests++;
    if ({px_s, py_s, hs_s, vs_s, bn_s, sn_s} !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_small: got x=%0d y=%0d outs=%b, expected all zero",
               px_s, py_s, {hs_s, vs_s, bn_s, sn_s});
    end
    rst = 1'b0;
    tick();
    n_tests++;
    if (px_b !== 10'd1 || py_b !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_release: got (%0d,%0d), expected (1,0)", px_b, py_b);
    end
  endtask

  // Line 0: observations posx 1..799 (posx 0 was seen under reset)
  task automatic test_hline();
    int hs_low;
    int bn_hi;
    hs_low = (hs_b == 1'b0) ? 1 : 0;
    bn_hi  = (bn_b == 1'b1) ? 1 : 0;
    repeat (798) begin
      tick();
      if (!hs_b) hs_low++;
      if (bn_b) bn_hi++;
    end
    n_tests++;
    if (hs_low != 95) begin
      n_fail++;
      $display("FAIL hline_hsync_low: got %0d, expected 95 (posx 1..95)", hs_low);
    end
    n_tests++;
    if (bn_hi != 0) begin
      n_fail++;
      $display("FAIL hline_blank: got %0d visible clks on line 0, expected 0", bn_hi);
    end
    n_tests++;
    if (px_b !== 10'd799 || py_b !== 10'd0) begin
      n_fail++;
      $display("FAIL hline_end: got (%0d,%0d), expected (799,0)", px_b, py_b);
    end
    tick();
    n_tests++;
    if (px_b !== 10'd0 || py_b !== 10'd1) begin
      n_fail++;
      $display("FAIL hline_wrap: got (%0d,%0d), expected (0,1)", px_b, py_b);
    end
  endtask

  task automatic test_active();
    int   bn_cnt;
    int   rise;
    int   fall;
    logic prev;
    repeat (34 * 800) tick();
    n_tests++;
    if (px_b !== 10'd0 || py_b !== 10'd35) begin
      n_fail++;
      $display("FAIL active_pos: got (%0d,%0d), expected (0,35)", px_b, py_b);
    end
    bn_cnt = 0;
    rise   = -1;
    fall   = -1;
    prev   = bn_b;
    repeat (800) begin
      tick();
      if (bn_b && !prev && rise < 0) rise = int'(px_b);
      if (!bn_b && prev && fall < 0) fall = int'(px_b);
      if (bn_b) bn_cnt++;
      prev = bn_b;
    end
    n_tests++;
    if (bn_cnt != 640) begin
      n_fail++;
      $display("FAIL active_count: got %0d visible clks, expected 640", bn_cnt);
    end
    n_tests++;
    if (rise != 144 || fall != 784) begin
      n_fail++;
      $display("FAIL active_edges: got rise=%0d fall=%0d, expected rise=144 fall=784", rise, fall);
    end
    // Lines 0 and 1 seen out of reset: posx 1..799 on line 0 plus 800 on line 1
    n_tests++;
    if (vs_low_b != 1599) begin
      n_fail++;
      $display("FAIL vsync_low: got %0d clks, expected 1599", vs_low_b);
    end
  endtask

  task automatic test_midreset();
    repeat (400) tick();
    n_tests++;
    if (px_b !== 10'd400 || py_b !== 10'd36) begin
      n_fail++;
      $display("FAIL midrst_pre: got (%0d,%0d), expected (400,36)", px_b, py_b);
    end
    rst = 1'b1;
    tick();
    n_tests++;
    if ({px_b, py_b, hs_b, vs_b, bn_b, sn_b} !== 24'd0) begin
      n_fail++;
      $display("FAIL midrst_state: got x=%0d y=%0d outs=%b, expected all zero",
               px_b, py_b, {hs_b, vs_b, bn_b, sn_b});
    end
    rst = 1'b0;
    tick();
    repeat (1600) tick();
    n_tests++;
    if (px_b !== 10'd1 || py_b !== 10'd2) begin
      n_fail++;
      $display("FAIL midrst_resume: got (%0d,%0d), expected (1,2)", px_b, py_b);
    end
  endtask

  // Small instance: one full 14 x 7 frame (98 clks) after reset
  task automatic test_frame();
    int         vs_low;
    int         bn_cnt;
    int         max_x;
    int         max_y;
    logic [7:0] vis_lines;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vs_low    = 0;
    bn_cnt    = 0;
    max_x     = 0;
    max_y     = 0;
    vis_lines = 8'd0;
    repeat (98) begin
      tick();
      if (!vs_s) vs_low++;
      if (bn_s) begin
        bn_cnt++;
        vis_lines[py_s[2:0]] = 1'b1;
      end
      if (int'(px_s) > max_x) max_x = int'(px_s);
      if (int'(py_s) > max_y) max_y = int'(py_s);
    end
    n_tests++;
    if (px_s !== 10'd0 || py_s !== 10'd0) begin
      n_fail++;
      $display("FAIL frame_wrap: got (%0d,%0d), expected (0,0)", px_s, py_s);
    end
    n_tests++;
    if (max_x != 13 || max_y != 6) begin
      n_fail++;
      $display("FAIL frame_max: got max (%0d,%0d), expected (13,6)", max_x, max_y);
    end
    // posx 1..13 on line 0 plus the final (0,0)
    n_tests++;
    if (vs_low != 14) begin
      n_fail++;
      $display("FAIL frame_vsync: got %0d clks, expected 14", vs_low);
    end
    n_tests++;
    if (bn_cnt != 32 || vis_lines !== 8'b0011_1100) begin
      n_fail++;
      $display("FAIL frame_visible: got %0d clks lines=%b, expected 32 lines=00111100",
               bn_cnt, vis_lines);
    end
  endtask

  initial begin
    test_reset();
    test_hline();
    test_active();
    test_midreset();
    test_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_vga_sync_gen
